physics_engine: RTL and testbench
=================================

PHYSICS_ENGINE -- requirements
Module: physics_engine

Interface
REQ-001 Parameter JUMP_TICKS, default 2: number of game ticks the unicorn stays up after a jump; legal values are 1 to 15.
REQ-002 Parameter GAP_MIN, default 2: minimum number of empty cells generated after each obstacle.
REQ-003 Parameter LFSR_SEED, default 8'hA5: LFSR reset value; a value of 0 is replaced by 8'h01.
REQ-004 CLK  in  1: the only clock; all state changes on the posedge.
REQ-005 RST  in  1: reset, synchronous, active-high.
REQ-006 tick  in  1: one-cycle game-step strobe; it is never high on two consecutive cycles.
REQ-007 jump_btn  in  1: raw button level, already synchronised to CLK.
REQ-008 jump  out  1: unicorn up when 1.
REQ-009 obstacle_first  out  2: cell 0, the unicorn digit; [1] = lower box, [0] = upper box.
REQ-010 obstacle_rest  out  14: cells 1..7; cell k occupies bits [2k-1:2k-2].
REQ-011 score_ones  out  4: BCD ones digit (0-9).
REQ-012 score_tens  out  4: BCD tens digit (0-9).
REQ-013 running  out  1: high in state RUN.
REQ-014 dead  out  1: high in state DEAD.

Function
REQ-015 The FSM shall have the states IDLE, RUN and DEAD, encoded in 2 bits.
REQ-016 A press shall be a rising edge of jump_btn, detected against a registered copy of the previous level; a level held high produces exactly one press.
REQ-017 In IDLE, a press shall move the FSM to RUN on the next edge with field empty, score 00 and jump=0; this start press does not trigger a jump.
REQ-018 In RUN, on each tick the field shall shift toward cell 0: cell k takes cell k+1 for k = 0..6, and cell 7 takes the generated cell.
REQ-019 Generated cell: if gap_cnt < GAP_MIN, the cell is 2'b00 and gap_cnt increments; otherwise lfsr[1:0] decides, 00/01 gives empty, 10 gives 2'b10 (lower box), 11 gives 2'b01 (upper box).
REQ-020 gap_cnt shall clear when a box is generated and shall saturate at GAP_MIN.
REQ-021 No generated cell shall ever equal 2'b11.
REQ-022 The LFSR shall be 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1.
REQ-023 The LFSR shall advance on every clock edge in every state except during RST.
REQ-024 In RUN, a press while jump=0 shall load jump_cnt=JUMP_TICKS and set jump=1 on the next edge.
REQ-025 A press while jump=1 shall be ignored.
REQ-026 jump_cnt shall decrement on each tick while nonzero; jump shall fall on the same edge at which jump_cnt reaches 0.
REQ-027 A press coinciding with a tick shall load jump_cnt, and the load takes priority over the decrement.
REQ-028 Collision shall be evaluated every cycle in RUN from the registered values: lethal = (cell0[1] and !jump) or (cell0[0] and jump).
REQ-029 When lethal, the FSM shall move to DEAD on the next edge.
REQ-030 A lethal cycle that coincides with a tick or a press shall go to DEAD, with no shift, no score change and no jump load.
REQ-031 On a non-lethal tick in RUN with cell0 != 00, the score shall increment by 1 in two-digit BCD: ones 9 rolls to 0 with a tens carry, and 99 wraps to 00.
REQ-032 In DEAD, the field, jump, jump_cnt and score shall be frozen, and ticks shall be ignored.
REQ-033 In DEAD, a press shall move the FSM to IDLE, clearing the field, jump, jump_cnt, gap_cnt and score.
REQ-034 Ticks shall be ignored in IDLE.
REQ-035 All outputs shall be registered, with no combinational input-to-output path.

Reset
REQ-036 RST shall force the following on the next edge, in any state including mid-RUN: state IDLE, all cells 00, jump=0, jump_cnt=0, gap_cnt=GAP_MIN, score 00, running=0, dead=0, lfsr=LFSR_SEED, and the button history register cleared.
REQ-037 RST shall take priority over tick and jump_btn.

Verification
REQ-038 RST high for 2 cycles -> all outputs 0, obstacle_rest=14'h0; after release, a held jump_btn produces exactly one IDLE->RUN transition.
REQ-039 RUN with empty cell0, press -> jump=1 next cycle; a second press is ignored; jump stays 1 through the first tick and falls at the edge of the 2nd tick (JUMP_TICKS=2).
REQ-040 Bench LFSR model with seed 8'hA5, 20 ticks -> obstacle cells match the model cycle-exactly, and no two boxes are closer than GAP_MIN+1 cells.
REQ-041 Lower box reaches cell0 with jump=0 -> dead=1 and running=0 one cycle later; 5 further ticks leave obstacle_first, obstacle_rest and score unchanged.
REQ-042 Upper box at cell0 with jump=0, and lower box at cell0 with jump=1 -> no death; score increments at the tick that shifts each box out; preload score 09 -> 10, and 99 -> 00.
REQ-043 Press in DEAD -> IDLE next cycle with score 00 and field empty; RST asserted mid-RUN with jump=1 -> reset values on the next edge.

Source files
------------

// File: rtl/physics_engine.sv
// -----------------------------------------------------------------------------
// physics_engine
//
// Game core for a one-row "unicorn runner". An 8-cell obstacle field scrolls
// toward cell 0 (the unicorn's digit) on every game tick. The player presses a
// button to jump. A lower box kills a grounded unicorn, and an upper box kills
// a jumping one. Every box that leaves cell 0 safely scores one point
// (two-digit BCD). New cells come from an 8-bit Fibonacci LFSR. After each box
// at least GAP_MIN empty cells are generated.
//
// Parameters
//   JUMP_TICKS  ticks the unicorn stays up after a jump (1..15)
//   GAP_MIN     minimum empty cells generated after every box
//   LFSR_SEED   LFSR reset value (0 is replaced by 8'h01)
//
// Ports
//   CLK             clock, all state changes on posedge
//   RST             synchronous active-high reset
//   tick            one-cycle game-step strobe (never high two cycles running)
//   jump_btn        button level, already synchronised to CLK
//   jump            unicorn is up
//   obstacle_first  cell 0: [1] lower box, [0] upper box
//   obstacle_rest   cells 1..7, cell k at bits [2k-1:2k-2]
//   score_ones      BCD ones digit
//   score_tens      BCD tens digit
//   running         FSM in RUN
//   dead            FSM in DEAD
//   state_dbg       raw FSM state (IDLE=0, RUN=1, DEAD=2)
// -----------------------------------------------------------------------------
module physics_engine #(
    parameter int unsigned JUMP_TICKS = 2,
    parameter int unsigned GAP_MIN    = 2,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tick,
    input  logic        jump_btn,
    output logic        jump,
    output logic [1:0]  obstacle_first,
    output logic [13:0] obstacle_rest,
    output logic [3:0]  score_ones,
    output logic [3:0]  score_tens,
    output logic        running,
    output logic        dead,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced with 1.
    localparam logic [7:0] SEED    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] GAP_LIM = 8'(GAP_MIN);
    localparam logic [3:0] JT      = 4'(JUMP_TICKS);

    state_t      state_q, state_d;
    logic        btn_q;
    logic [7:0]  lfsr_q;
    logic [15:0] field_q, field_d;     // cell k at [2k+1:2k]
    logic        jump_q, jump_d;
    logic [3:0]  jump_cnt_q, jump_cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;

    logic        press;
    logic        lethal;
    logic [1:0]  gen_cell;
    logic [7:0]  gap_gen;
    logic        lfsr_fb;

    // Rising edge of the button against last cycle's level.
    assign press   = jump_btn & ~btn_q;
    // Taps for x^8+x^6+x^5+x^4+1.
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    // Only registered values feed the collision test.
    assign lethal  = (field_q[1] & ~jump_q) | (field_q[0] & jump_q);

    // Cell generator. It is only committed on a live tick in RUN.
    always_comb begin
        gen_cell = 2'b00;
        gap_gen  = gap_q;
        if (gap_q < GAP_LIM) begin
            gap_gen = gap_q + 8'd1;
        end else begin
            unique case (lfsr_q[1:0])
                2'b10: begin
                    gen_cell = 2'b10;
                    gap_gen  = 8'd0;
                end
                2'b11: begin
                    gen_cell = 2'b01;
                    gap_gen  = 8'd0;
                end
                default: begin
                    gen_cell = 2'b00;
                    gap_gen  = gap_q;   // already saturated at GAP_MIN
                end
            endcase
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        field_d    = field_q;
        jump_d     = jump_q;
        jump_cnt_d = jump_cnt_q;
        gap_d      = gap_q;
        ones_d     = ones_q;
        tens_d     = tens_q;

        unique case (state_q)
            IDLE: begin
                // The start press only starts the game. It does not jump.
                if (press) begin
                    state_d    = RUN;
                    field_d    = 16'h0000;
                    jump_d     = 1'b0;
                    jump_cnt_d = 4'd0;
                    ones_d     = 4'd0;
                    tens_d     = 4'd0;
                end
            end
            RUN: begin
                if (lethal) begin
                    // Death wins over the shift, the score and any jump load.
                    state_d = DEAD;
                end else begin
                    if (tick) begin
                        field_d = {gen_cell, field_q[15:2]};
                        gap_d   = gap_gen;
                        // The box leaving cell 0 survived, so it scores.
                        if (field_q[1:0] != 2'b00) begin
                            if (ones_q == 4'd9) begin
                                ones_d = 4'd0;
                                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                            end else begin
                                ones_d = ones_q + 4'd1;
                            end
                        end
                    end
                    // The load wins over a coincident tick decrement.
                    if (press && !jump_q) begin
                        jump_cnt_d = JT;
                        jump_d     = 1'b1;
                    end else if (tick && (jump_cnt_q != 4'd0)) begin
                        jump_cnt_d = jump_cnt_q - 4'd1;
                        jump_d     = (jump_cnt_q != 4'd1);
                    end
                end
            end
            DEAD: begin
                if (press) begin
                    state_d    = IDLE;
                    field_d    = 16'h0000;
                    jump_d     = 1'b0;
                    jump_cnt_d = 4'd0;
                    gap_d      = 8'd0;
                    ones_d     = 4'd0;
                    tens_d     = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            btn_q      <= 1'b0;
            lfsr_q     <= SEED;
            field_q    <= 16'h0000;
            jump_q     <= 1'b0;
            jump_cnt_q <= 4'd0;
            gap_q      <= GAP_LIM;
            ones_q     <= 4'd0;
            tens_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            btn_q      <= jump_btn;
            lfsr_q     <= {lfsr_q[6:0], lfsr_fb};
            field_q    <= field_d;
            jump_q     <= jump_d;
            jump_cnt_q <= jump_cnt_d;
            gap_q      <= gap_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
        end
    end

    assign jump           = jump_q;
    assign obstacle_first = field_q[1:0];
    assign obstacle_rest  = field_q[15:2];
    assign score_ones     = ones_q;
    assign score_tens     = tens_q;
    assign running        = (state_q == RUN);
    assign dead           = (state_q == DEAD);
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_physics_engine.sv
// -----------------------------------------------------------------------------
// tb_physics_engine
//
// Self-checking bench for physics_engine. A behavioural game model predicts
// every output after each clock. Predictions are queued when the inputs are
// driven and compared after the edge. Hand-written expectations cover
// the start/jump timing table, death, the freeze in DEAD, the restart, the
// BCD roll-overs and reset in the middle of a run.
// -----------------------------------------------------------------------------
module tb_physics_engine;

    localparam int         JT   = 2;
    localparam int         GM   = 2;
    localparam logic [7:0] SEED = 8'hA5;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_RUN  = 2'd1;
    localparam logic [1:0] M_DEAD = 2'd2;

    // ---------------- clock / reset / DUT ----------------
    logic        CLK      = 1'b0;
    logic        RST      = 1'b0;
    logic        tick     = 1'b0;
    logic        jump_btn = 1'b0;
    logic        jump;
    logic [1:0]  obstacle_first;
    logic [13:0] obstacle_rest;
    logic [3:0]  score_ones;
    logic [3:0]  score_tens;
    logic        running;
    logic        dead;
    logic [1:0]  state_dbg;

    always #5 CLK = ~CLK;

    physics_engine #(
        .JUMP_TICKS(JT),
        .GAP_MIN   (GM),
        .LFSR_SEED (SEED)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .tick          (tick),
        .jump_btn      (jump_btn),
        .jump          (jump),
        .obstacle_first(obstacle_first),
        .obstacle_rest (obstacle_rest),
        .score_ones    (score_ones),
        .score_tens    (score_tens),
        .running       (running),
        .dead          (dead),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int           checks = 0;
    int           errors = 0;
    logic [28:0]  exp_q[$];
    string        cur_label = "init";

    // ---------------- reference model ----------------
    logic [1:0] m_state = M_IDLE;
    logic       m_btn   = 1'b0;
    logic [7:0] m_lfsr  = SEED;
    logic [1:0] m_cell[8];
    logic       m_jump  = 1'b0;
    int         m_jcnt  = 0;
    int         m_gap   = GM;
    int         m_score = 0;

    function automatic logic [28:0] model_vec();
        logic [13:0] rest;
        rest = '0;
        for (int k = 1; k < 8; k++) rest[(2*k-2) +: 2] = m_cell[k];
        return {m_state, m_jump, rest, m_cell[0],
                4'(m_score / 10), 4'(m_score % 10),
                (m_state == M_RUN), (m_state == M_DEAD)};
    endfunction

    function automatic logic [28:0] dut_vec();
        return {state_dbg, jump, obstacle_rest, obstacle_first,
                score_tens, score_ones, running, dead};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) m_cell[k] = 2'b00;
        m_jump  = 1'b0;
        m_jcnt  = 0;
        m_score = 0;
    endtask

    task automatic model_step(input logic r, input logic t, input logic b);
        logic       press;
        logic       lethal;
        logic [1:0] gen;
        if (r) begin
            m_state = M_IDLE;
            model_clear();
            m_gap  = GM;
            m_lfsr = SEED;
            m_btn  = 1'b0;
        end else begin
            press  = b && !m_btn;
            lethal = (m_cell[0] == 2'b10 && !m_jump) || (m_cell[0] == 2'b01 && m_jump);
            case (m_state)
                M_IDLE: if (press) begin
                    m_state = M_RUN;
                    model_clear();
                end
                M_RUN: if (lethal) begin
                    m_state = M_DEAD;
                end else begin
                    if (t) begin
                        gen = 2'b00;
                        if (m_gap < GM) begin
                            m_gap++;
                        end else begin
                            if (m_lfsr[1:0] == 2'b10) gen = 2'b10;
                            if (m_lfsr[1:0] == 2'b11) gen = 2'b01;
                            if (gen != 2'b00) m_gap = 0;
                        end
                        if (m_cell[0] != 2'b00) m_score = (m_score + 1) % 100;
                        for (int k = 0; k < 7; k++) m_cell[k] = m_cell[k+1];
                        m_cell[7] = gen;
                    end
                    if (press && !m_jump) begin
                        m_jcnt = JT;
                        m_jump = 1'b1;
                    end else if (t && m_jcnt > 0) begin
                        m_jcnt--;
                        if (m_jcnt == 0) m_jump = 1'b0;
                    end
                end
                M_DEAD: if (press) begin
                    m_state = M_IDLE;
                    model_clear();
                    m_gap = 0;
                end
                default: m_state = M_IDLE;
            endcase
            m_btn  = b;
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
        exp_q.push_back(model_vec());
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_pop();
        logic [28:0] e;
        if (exp_q.size() == 0) begin
            chk({cur_label, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(cur_label, 32'(dut_vec()), 32'(e));
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic r, input logic t, input logic b);
        @(negedge CLK);
        RST      = r;
        tick     = t;
        jump_btn = b;
        model_step(r, t, b);
        @(posedge CLK);
        #1;
        check_pop();
    endtask

    // Returns 1 if any cell is 11 or two boxes sit closer than GM+1 cells.
    function automatic logic spacing_bad();
        logic [1:0] c[8];
        logic       bad;
        bad  = 1'b0;
        c[0] = obstacle_first;
        for (int k = 1; k < 8; k++) c[k] = obstacle_rest[(2*k-2) +: 2];
        for (int i = 0; i < 8; i++) begin
            if (c[i] == 2'b11) bad = 1'b1;
            for (int j = i + 1; j < 8; j++)
                if (c[i] != 2'b00 && c[j] != 2'b00 && (j - i) < GM + 1) bad = 1'b1;
        end
        return bad;
    endfunction

    // One game step: a pre-tick cycle (optionally pressing to clear a lower
    // box sitting in cell 1), then the tick cycle.
    task automatic play_tick(input logic autojump);
        logic p;
        p = autojump && (m_cell[1] == 2'b10) && !m_jump && (m_state == M_RUN);
        cycle(1'b0, 1'b0, p);
        cycle(1'b0, 1'b1, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic rst;
        logic tick;
        logic btn;
        logic e_jump;
        logic e_run;
        logic e_dead;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [7:0]  prev_score;
        logic [7:0]  now_score;
        logic        saw09;
        logic        saw99;
        logic        died;
        logic [23:0] snap;

        for (int k = 0; k < 8; k++) m_cell[k] = 2'b00;

        //            rst  tick btn  jump run  dead
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};  // start press
        vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};  // held: no new press
        vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b0};  // held over a tick
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};  // jump press
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0};  // press while up: ignored
        vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};  // first tick: still up
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};  // second tick: falls
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};

        cur_label = "table";
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].rst, vecs[i].tick, vecs[i].btn);
            chk("table_flags", {29'd0, jump, running, dead},
                {29'd0, vecs[i].e_jump, vecs[i].e_run, vecs[i].e_dead});
            if (i == 1) chk("reset_all_zero", 32'(dut_vec()), 32'd0);
        end

        // Fresh seed, 20 ticks of play against the model plus spacing rules.
        cur_label = "lfsr_run";
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            play_tick(1'b1);
            chk("spacing", {31'd0, spacing_bad()}, 32'd0);
        end

        // Keep playing until the score has rolled 09->10 and 99->00.
        cur_label = "score_run";
        saw09 = 1'b0;
        saw99 = 1'b0;
        for (int t = 0; t < 1500 && !saw99; t++) begin
            prev_score = {score_tens, score_ones};
            play_tick(1'b1);
            now_score = {score_tens, score_ones};
            if (prev_score == 8'h09 && now_score != prev_score) begin
                chk("bcd_09_to_10", 32'(now_score), 32'h10);
                saw09 = 1'b1;
            end
            if (prev_score == 8'h99 && now_score != prev_score) begin
                chk("bcd_99_to_00", 32'(now_score), 32'h00);
                saw99 = 1'b1;
            end
        end
        chk("saw_rollovers", {30'd0, saw09, saw99}, 32'd3);
        chk("alive_after_play", {31'd0, running}, 32'd1);

        // Stop jumping: the first lower box to reach cell 0 is fatal.
        cur_label = "death_run";
        died = 1'b0;
        for (int t = 0; t < 300 && !died; t++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (m_state == M_DEAD) begin
                died = 1'b1;
                chk("death_flags", {30'd0, dead, running}, 32'd2);
                chk("death_cell", 32'(obstacle_first), 32'h2);
            end else begin
                cycle(1'b0, 1'b1, 1'b0);
            end
        end
        chk("death_reached", {31'd0, died}, 32'd1);

        // Frozen while dead, ticks ignored.
        cur_label = "dead_freeze_run";
        snap = {obstacle_rest, obstacle_first, score_tens, score_ones};
        for (int t = 0; t < 5; t++) begin
            cycle(1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
            chk("dead_freeze", 32'({obstacle_rest, obstacle_first, score_tens, score_ones}),
                32'(snap));
        end

        // Press in DEAD returns to IDLE with everything cleared.
        cur_label = "restart";
        cycle(1'b0, 1'b0, 1'b1);
        chk("dead_to_idle", 32'(dut_vec()), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("idle_ignores_tick", 32'(dut_vec()), 32'd0);

        // Start, play a little, jump, then reset while up (with tick and btn high).
        cur_label = "rst_midrun_seq";
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) play_tick(1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("jump_before_rst", {31'd0, jump}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("rst_midrun", 32'(dut_vec()), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("idle_after_rst", 32'(dut_vec()), 32'd0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
